sum_store_ram: RTL
==================

// Module: sum_store_ram
// PURPOSE
//   Parametrised operand-sum store. Computes a+b and writes it, or accumulates it, into a
//   synchronous RAM entry addressed by {a,b}. Reads the entry back with a valid strobe.
//   Clears the whole array after reset. Sits behind the operand-generation logic.
// PARAMETERS
//   OPW   4            operand width; sum width is OPW+1
//   MW    8            stored word width (MW >= OPW+1); sum is zero-extended to MW
//   AW    2*OPW        address width (derived, do not override); address = {a,b}
//   DEPTH 2**(2*OPW)   number of entries (derived)
// PORTS
//   clk        in   1    clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   a          in   OPW  operand A, address high half
//   b          in   OPW  operand B, address low half
//   cs         in   1    chip select; request ignored when 0
//   we         in   1    1 = write/accumulate, 0 = read
//   acc        in   1    with we=1: 1 = accumulate (RMW), 0 = plain write
//   in_valid   in   1    request valid
//   in_ready   out  1    block can accept a request this cycle
//   dout       out  MW   read or accumulate result
//   dout_valid out  1    one-cycle strobe, dout is new
//   init_done  out  1    array clear complete, stays 1 until next reset
// BEHAVIOUR
//   Reset (async, rst_n=0):
//   - dout=0, dout_valid=0, in_ready=0, init_done=0, state=INIT, clear counter=0.
//   - Takes effect immediately, including mid-RMW; a pending RMW is discarded.
//   - Array contents are don't-care until re-cleared.
//   State INIT:
//   - One word per cycle: mem[cnt]<=0, cnt++, for DEPTH cycles.
//   - After the write to DEPTH-1: state=IDLE. init_done=1 and in_ready=1 from the next cycle.
//   - Inputs are ignored throughout INIT.
//   Accept = in_valid & in_ready & cs. in_valid with cs=0 is no-op: no array access, dout holds,
//   dout_valid=0.
//   IDLE, accept, we=0 (read):
//   - dout<=mem[{a,b}] and dout_valid=1 on the cycle after accept.
//   - Read latency is 1. Back-to-back reads give one result per cycle.
//   IDLE, accept, we=1, acc=0 (write):
//   - mem[{a,b}]<=zext(a+b) at the accept edge. dout unchanged, dout_valid=0.
//   - A read of the same address on the next cycle returns the new value.
//   IDLE, accept, we=1, acc=1 (accumulate):
//   - Accept edge: latch addr and sum, read the old word, state=RMW, in_ready=0 for one cycle.
//   - RMW edge: new = old+sum, saturated at 2**MW-1. Write new to the array, dout<=new,
//     dout_valid=1, state=IDLE.
//   - Throughput is one accumulate per 2 cycles.
//   Arithmetic:
//   - a+b is computed in OPW+1 bits and never overflows.
//   - Accumulation is done in MW+1 bits, then clamped to MW bits.
//   - Addresses never wrap, because {a,b} covers the full DEPTH.
//   Simultaneous events: none possible. in_ready=0 in INIT and RMW, so at most one array
//   operation occurs per cycle.
// STRUCTURE
//   sum_store_pkg:
//   - state enum {INIT, IDLE, RMW}
//   - OPW/MW default localparams
//   - sat_add function (MW-bit saturating add)
//   sum_store_mem (sub-module):
//   - single-port synchronous array, DEPTH x MW
//   - ports: clk, en, we, addr, wdata, rdata
//   - registered read, no reset on storage
//   Top level holds the FSM, clear counter, operand/sum registers, muxes onto the single port,
//   and the output registers.
// TESTING (OPW=4, MW=8)
//   1. rst_n low 3 cycles, then release:
//      in_ready=0 for 256 cycles, init_done=1 at cycle 257; read a=2,b=8 -> dout=0, dout_valid=1.
//   2. Write a=10,b=8 then read a=10,b=8:
//      dout=18 (0x12) one cycle after the read accept; the write cycle shows dout_valid=0.
//   3. Accumulate a=15,b=3 twice:
//      dout=18 then 36; in_ready=0 the cycle after each accept; a following read returns 36.
//   4. Accumulate a=15,b=15 ten times:
//      dout=30,60,...,240, then 255 (saturated); an 11th accumulate gives 255.
//   5. Write a=4,b=8 with cs=0, then read a=4,b=8 with cs=1:
//      dout=0, no dout_valid during cs=0, dout held across the cs=0 cycle.
//   6. Assert rst_n mid-RMW (a=5,b=7):
//      outputs go to 0 immediately, INIT reruns 256 cycles, read a=5,b=7 -> dout=0.

Source files
------------

// File: rtl/sum_store_pkg.sv
// sum_store_pkg
//   Shared types and helpers for the operand-sum store.
//   - state_t : controller states (INIT clears the array, IDLE serves
//               requests, RMW completes an accumulate)
//   - OPW_DEF / MW_DEF : default operand and stored-word widths
//   - sat_add : unsigned add clamped to 2**w-1, usable for any w <= 32
package sum_store_pkg;

    localparam int unsigned OPW_DEF = 4;
    localparam int unsigned MW_DEF  = 8;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        RMW  = 2'd2
    } state_t;

    // Adds in one extra bit so the carry is visible, then clamps to the
    // largest w-bit value. Callers pass zero-extended operands of width w.
    function automatic logic [31:0] sat_add(input logic [31:0]  x,
                                            input logic [31:0]  y,
                                            input int unsigned  w);
        logic [32:0] s;
        logic [32:0] lim;
        s   = {1'b0, x} + {1'b0, y};
        lim = (33'd1 << w) - 33'd1;
        return (s > lim) ? lim[31:0] : s[31:0];
    endfunction

endpackage

// File: rtl/sum_store_mem.sv
// sum_store_mem
//   Single-port synchronous array, DEPTH x MW. Storage has no reset.
//   Ports:
//     clk   in   clock, rising edge
//     en    in   port enable; no access when 0
//     we    in   1 = write wdata to addr, 0 = read addr into rdata
//     addr  in   word address
//     wdata in   write data
//     rdata out  registered read data; holds its value on writes/idle
module sum_store_mem #(
    parameter int unsigned AW = 8,
    parameter int unsigned MW = 8
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [MW-1:0] wdata,
    output logic [MW-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [MW-1:0] mem_q [DEPTH];
    logic [MW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sum_store_ram.sv
// sum_store_ram
//   Operand-sum store: computes a+b and writes or accumulates it (saturating)
//   into the array entry addressed by {a,b}; reads entries back with a
//   one-cycle valid strobe. Clears the whole array after every reset.
//   Ports:
//     clk, rst_n  clock (rising) and asynchronous active-low reset
//     a, b        operands; {a,b} is the entry address
//     cs, we, acc chip select, write/read, accumulate-vs-plain-write
//     in_valid    request valid; accepted when in_valid & in_ready & cs
//     in_ready    request can be accepted this cycle
//     dout        read or accumulate result
//     dout_valid  one-cycle strobe, dout is new
//     init_done   array clear complete, held until next reset
module sum_store_ram
    import sum_store_pkg::*;
#(
    parameter int unsigned OPW = OPW_DEF,
    parameter int unsigned MW  = MW_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    input  logic           cs,
    input  logic           we,
    input  logic           acc,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [MW-1:0]  dout,
    output logic           dout_valid,
    output logic           init_done
);

    localparam int unsigned AW    = 2 * OPW;
    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t         state_q,      state_d;
    logic [AW-1:0]  cnt_q,        cnt_d;
    logic [AW-1:0]  addr_q,       addr_d;
    logic [OPW:0]   sum_q,        sum_d;
    logic [MW-1:0]  dout_q,       dout_d;
    logic           dout_valid_q, dout_valid_d;
    logic           rd_pend_q,    rd_pend_d;
    logic           in_ready_q,   in_ready_d;
    logic           init_done_q,  init_done_d;

    logic           mem_en;
    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [MW-1:0]  mem_wdata;
    logic [MW-1:0]  mem_rdata;

    logic           accept;
    logic [AW-1:0]  addr_in;
    logic [OPW:0]   sum_in;
    logic [MW-1:0]  acc_val;

    assign accept  = in_valid & in_ready_q & cs;
    assign addr_in = {a, b};
    assign sum_in  = {1'b0, a} + {1'b0, b};
    assign acc_val = MW'(sat_add(32'(mem_rdata), 32'(sum_q), MW));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        sum_d        = sum_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        rd_pend_d    = 1'b0;
        in_ready_d   = in_ready_q;
        init_done_d  = init_done_q;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = addr_in;
        mem_wdata    = MW'(sum_in);

        // Read data arrives straight from the array register; capture it
        // so dout holds once the strobe cycle is over.
        if (rd_pend_q) begin
            dout_d = mem_rdata;
        end

        unique case (state_q)
            INIT: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cnt_q;
                mem_wdata = '0;
                cnt_d     = cnt_q + AW'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d     = IDLE;
                    in_ready_d  = 1'b1;
                    init_done_d = 1'b1;
                end
            end
            IDLE: begin
                if (accept) begin
                    mem_en = 1'b1;
                    if (we && !acc) begin
                        mem_we = 1'b1;
                    end else if (we && acc) begin
                        // Old word is read this edge, combined next edge.
                        addr_d     = addr_in;
                        sum_d      = sum_in;
                        state_d    = RMW;
                        in_ready_d = 1'b0;
                    end else begin
                        rd_pend_d    = 1'b1;
                        dout_valid_d = 1'b1;
                    end
                end
            end
            RMW: begin
                mem_en       = 1'b1;
                mem_we       = 1'b1;
                mem_addr     = addr_q;
                mem_wdata    = acc_val;
                dout_d       = acc_val;
                dout_valid_d = 1'b1;
                state_d      = IDLE;
                in_ready_d   = 1'b1;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= INIT;
            cnt_q        <= '0;
            addr_q       <= '0;
            sum_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            rd_pend_q    <= 1'b0;
            in_ready_q   <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            sum_q        <= sum_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            rd_pend_q    <= rd_pend_d;
            in_ready_q   <= in_ready_d;
            init_done_q  <= init_done_d;
        end
    end

    sum_store_mem #(
        .AW (AW),
        .MW (MW)
    ) u_mem (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // While a read result is pending the array register is the output;
    // otherwise the held/accumulated value is.
    assign dout       = rd_pend_q ? mem_rdata : dout_q;
    assign dout_valid = dout_valid_q;
    assign in_ready   = in_ready_q;
    assign init_done  = init_done_q;

endmodule
